// File: rtl/fdma_arb_pkg.sv
// Shared FDMA arbiter definitions: FSM state encoding, channel count and the
// round-robin rotate helper used by the channel pickers.
package fdma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam int unsigned NUM_CH = 4;

  // Bit i of the result is the request of channel (last+1+i) mod 4.
  function automatic logic [3:0] rotate_req(input logic [3:0] req, input logic [1:0] last);
    logic [3:0] rot;
    logic [1:0] pos;
    rot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = last + 2'd1 + 2'(i);
      rot[2'(i)] = req[pos];
    end
    return rot;
  endfunction

endpackage

// File: rtl/fdma_rd_arbiter_4ch_rr_pick4.sv
// rr_pick4: combinational round-robin picker; the first requester after
// 'last' (wrapping) wins.
module rr_pick4
  import fdma_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       hit,
  output logic [1:0] idx
);

  logic [3:0] rot;

  always_comb begin
    rot = rotate_req(req, last);
    hit = |rot;
    idx = last + 2'd1;
    // Walk from the far end so the nearest requester after 'last' wins.
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (rot[2'(i - 1)]) idx = last + 2'd1 + 2'(i - 1);
    end
  end

endmodule

// File: rtl/fdma_rd_arbiter_4ch.sv
// Four-channel round-robin FDMA read arbiter (one burst per grant).
// Optional REQ-state watchdog enabled by defining FDMA_RD_ARB_TIMEOUT_EN.
module fdma_rd_arbiter_4ch
  import fdma_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21
`ifdef FDMA_RD_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC    = 1024
`endif
)
(
  input  logic                      ui_clk,
  input  logic                      ui_rstn,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_1,
  input  logic                      fdma_rareq_1,
  input  logic [15:0]               fdma_rsize_1,
  output logic                      fdma_rbusy_1,
  output logic                      fdma_rvalid_1,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_1,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_2,
  input  logic                      fdma_rareq_2,
  input  logic [15:0]               fdma_rsize_2,
  output logic                      fdma_rbusy_2,
  output logic                      fdma_rvalid_2,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_2,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_3,
  input  logic                      fdma_rareq_3,
  input  logic [15:0]               fdma_rsize_3,
  output logic                      fdma_rbusy_3,
  output logic                      fdma_rvalid_3,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_3,
  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_4,
  input  logic                      fdma_rareq_4,
  input  logic [15:0]               fdma_rsize_4,
  output logic                      fdma_rbusy_4,
  output logic                      fdma_rvalid_4,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_4,
  output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
  output logic                      fdma_rareq,
  output logic [15:0]               fdma_rsize,
  input  logic                      fdma_rbusy,
  input  logic                      fdma_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata
`ifdef FDMA_RD_ARB_TIMEOUT_EN
  ,
  output logic                      fdma_rd_timeout
`endif
);

  arb_state_t                state;
  logic [1:0]                sel;
  logic [1:0]                last;
  logic [3:0]                rbusy_q;
  logic                      rbusy_dly;
  logic [3:0]                req_v;
  logic                      pick_hit;
  logic [1:0]                pick_idx;
  logic                      active;
  logic [3:0]                rvalid_v;
  logic [AXI_ADDR_WIDTH-1:0] addr_v  [NUM_CH];
  logic [15:0]               size_v  [NUM_CH];
  logic [AXI_DATA_WIDTH-1:0] rdata_v [NUM_CH];
`ifdef FDMA_RD_ARB_TIMEOUT_EN
  logic [15:0]               to_cnt;
`endif

  assign req_v     = {fdma_rareq_4, fdma_rareq_3, fdma_rareq_2, fdma_rareq_1};
  assign addr_v[0] = fdma_raddr_1;
  assign addr_v[1] = fdma_raddr_2;
  assign addr_v[2] = fdma_raddr_3;
  assign addr_v[3] = fdma_raddr_4;
  assign size_v[0] = fdma_rsize_1;
  assign size_v[1] = fdma_rsize_2;
  assign size_v[2] = fdma_rsize_3;
  assign size_v[3] = fdma_rsize_4;

  rr_pick4 u_pick (
    .req  (req_v),
    .last (last),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state      <= IDLE;
      sel        <= 2'd0;
      last       <= 2'd3;
      fdma_raddr <= '0;
      fdma_rareq <= 1'b0;
      fdma_rsize <= '0;
      rbusy_q    <= '0;
      rbusy_dly  <= 1'b0;
`ifdef FDMA_RD_ARB_TIMEOUT_EN
      to_cnt          <= '0;
      fdma_rd_timeout <= 1'b0;
`endif
    end else begin
      // Sampled in every state so the first BUSY cycle already sees the
      // high level that moved REQ->BUSY; a one-cycle busy pulse still falls.
      rbusy_dly <= fdma_rbusy;
`ifdef FDMA_RD_ARB_TIMEOUT_EN
      fdma_rd_timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_hit) begin
            sel        <= pick_idx;
            fdma_raddr <= addr_v[pick_idx];
            fdma_rsize <= size_v[pick_idx];
            fdma_rareq <= 1'b1;
            rbusy_q    <= 4'b0001 << pick_idx;
            state      <= REQ;
`ifdef FDMA_RD_ARB_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        REQ: begin
          if (fdma_rbusy) begin
            fdma_rareq <= 1'b0;
            state      <= BUSY;
          end
`ifdef FDMA_RD_ARB_TIMEOUT_EN
          else if (to_cnt == 16'(TIMEOUT_CYC - 1)) begin
            fdma_rareq      <= 1'b0;
            fdma_rd_timeout <= 1'b1;
            last            <= sel;
            rbusy_q         <= '0;
            state           <= DONE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        BUSY: begin
          if (rbusy_dly && !fdma_rbusy) begin
            last    <= sel;
            rbusy_q <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          fdma_raddr <= '0;
          fdma_rsize <= '0;
          rbusy_q    <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign active = (state == REQ) || (state == BUSY);

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rvalid_v[2'(i)] = fdma_rvalid & active & (sel == 2'(i));
      rdata_v[2'(i)]  = (active && (sel == 2'(i))) ? fdma_rdata : '0;
    end
  end

  assign fdma_rbusy_1  = rbusy_q[0];
  assign fdma_rbusy_2  = rbusy_q[1];
  assign fdma_rbusy_3  = rbusy_q[2];
  assign fdma_rbusy_4  = rbusy_q[3];
  assign fdma_rvalid_1 = rvalid_v[0];
  assign fdma_rvalid_2 = rvalid_v[1];
  assign fdma_rvalid_3 = rvalid_v[2];
  assign fdma_rvalid_4 = rvalid_v[3];
  assign fdma_rdata_1  = rdata_v[0];
  assign fdma_rdata_2  = rdata_v[1];
  assign fdma_rdata_3  = rdata_v[2];
  assign fdma_rdata_4  = rdata_v[3];

endmodule

// File: tb/tb_fdma_rd_arbiter_4ch.sv
// Directed bench for fdma_rd_arbiter_4ch: reset, single burst, round-robin,
// wrap, stray beats and (with FDMA_RD_ARB_TIMEOUT_EN) the REQ watchdog.
module tb_fdma_rd_arbiter_4ch;

  localparam int DW = 32;
  localparam int AW = 21;

  logic ui_clk  = 1'b0;
  logic ui_rstn = 1'b0;
  always #5 ui_clk = ~ui_clk;

  logic [AW-1:0] ch_addr [4];
  logic [15:0]   ch_size [4];
  logic [3:0]    req_v;
  logic          rb1, rb2, rb3, rb4;
  logic          rv1, rv2, rv3, rv4;
  logic [DW-1:0] rd1, rd2, rd3, rd4;
  logic [AW-1:0] fdma_raddr;
  logic          fdma_rareq;
  logic [15:0]   fdma_rsize;
  logic          fdma_rbusy;
  logic          fdma_rvalid;
  logic [DW-1:0] fdma_rdata;
`ifdef FDMA_RD_ARB_TIMEOUT_EN
  logic          fdma_rd_timeout;
`endif

  logic [3:0] busy_vec;
  logic [3:0] rvalid_vec;
  assign busy_vec   = {rb4, rb3, rb2, rb1};
  assign rvalid_vec = {rv4, rv3, rv2, rv1};

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fdma_rd_arbiter_4ch #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW)
`ifdef FDMA_RD_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC    (16)
`endif
  ) dut (
    .ui_clk        (ui_clk),
    .ui_rstn       (ui_rstn),
    .fdma_raddr_1  (ch_addr[0]),
    .fdma_rareq_1  (req_v[0]),
    .fdma_rsize_1  (ch_size[0]),
    .fdma_rbusy_1  (rb1),
    .fdma_rvalid_1 (rv1),
    .fdma_rdata_1  (rd1),
    .fdma_raddr_2  (ch_addr[1]),
    .fdma_rareq_2  (req_v[1]),
    .fdma_rsize_2  (ch_size[1]),
    .fdma_rbusy_2  (rb2),
    .fdma_rvalid_2 (rv2),
    .fdma_rdata_2  (rd2),
    .fdma_raddr_3  (ch_addr[2]),
    .fdma_rareq_3  (req_v[2]),
    .fdma_rsize_3  (ch_size[2]),
    .fdma_rbusy_3  (rb3),
    .fdma_rvalid_3 (rv3),
    .fdma_rdata_3  (rd3),
    .fdma_raddr_4  (ch_addr[3]),
    .fdma_rareq_4  (req_v[3]),
    .fdma_rsize_4  (ch_size[3]),
    .fdma_rbusy_4  (rb4),
    .fdma_rvalid_4 (rv4),
    .fdma_rdata_4  (rd4),
    .fdma_raddr    (fdma_raddr),
    .fdma_rareq    (fdma_rareq),
    .fdma_rsize    (fdma_rsize),
    .fdma_rbusy    (fdma_rbusy),
    .fdma_rvalid   (fdma_rvalid),
    .fdma_rdata    (fdma_rdata)
`ifdef FDMA_RD_ARB_TIMEOUT_EN
    ,
    .fdma_rd_timeout (fdma_rd_timeout)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] pick_rd(input logic [3:0] oh);
    case (oh)
      4'b0001: return rd1;
      4'b0010: return rd2;
      4'b0100: return rd3;
      4'b1000: return rd4;
      default: return '0;
    endcase
  endfunction

  task automatic wait_rareq(output int unsigned waited);
    waited = 0;
    while (!fdma_rareq && waited < 20) begin
      tick();
      waited++;
    end
    if (!fdma_rareq) check("rareq_wait", 64'd0, 64'd1);
  endtask

  // Master model for one granted burst: 'pre' REQ cycles before busy, then
  // 'beats' data beats, then the DONE and IDLE cycles with stray beats applied.
  task automatic run_burst(input int unsigned pre, input int unsigned beats,
                           input logic [3:0] exp_oh, input bit drop_req,
                           input string tag, output int unsigned waited);
    int unsigned good, bad, hold_bad;
    int ch;
    wait_rareq(waited);
    ch = oh_idx(exp_oh);
    check({tag, "_grant"}, busy_vec, exp_oh);
    check({tag, "_raddr"}, fdma_raddr, ch_addr[ch]);
    check({tag, "_rsize"}, fdma_rsize, ch_size[ch]);
    if (drop_req) req_v[ch] = 1'b0;
    hold_bad = 0;
    repeat (pre) begin
      tick();
      if (!fdma_rareq || fdma_raddr !== ch_addr[ch] || busy_vec !== exp_oh) hold_bad++;
    end
    check({tag, "_req_hold"}, hold_bad, 0);
    fdma_rbusy = 1'b1;
    tick();
    check({tag, "_rareq_drop"}, fdma_rareq, 1'b0);
    check({tag, "_busy_held"}, busy_vec, exp_oh);
    good = 0;
    bad  = 0;
    for (int unsigned k = 0; k < beats; k++) begin
      fdma_rvalid = 1'b1;
      fdma_rdata  = {8'(ch + 1), 24'(k)};
      #1;
      if (rvalid_vec === exp_oh && pick_rd(exp_oh) === fdma_rdata) good++;
      else bad++;
      tick();
    end
    fdma_rvalid = 1'b0;
    fdma_rbusy  = 1'b0;
    if (beats > 0) check({tag, "_beats"}, {32'(good), 32'(bad)}, {32'(beats), 32'd0});
    tick();
    fdma_rvalid = 1'b1;
    fdma_rdata  = '1;
    #1;
    check({tag, "_done_busy"}, {busy_vec, fdma_rareq}, 5'b0);
    check({tag, "_stray_done"}, rvalid_vec, 4'b0);
    tick();
    check({tag, "_stray_idle"}, rvalid_vec, 4'b0);
    check({tag, "_idle_clear"}, {fdma_raddr, fdma_rsize, fdma_rareq}, '0);
    fdma_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned w;
    int unsigned stray;
    ch_addr[0] = 21'h000100; ch_size[0] = 16'd16;
    ch_addr[1] = 21'h001000; ch_size[1] = 16'd64;
    ch_addr[2] = 21'h012340; ch_size[2] = 16'd8;
    ch_addr[3] = 21'h1FFFC0; ch_size[3] = 16'd4;
    req_v       = 4'b1111;
    fdma_rbusy  = 1'b0;
    fdma_rvalid = 1'b1;
    fdma_rdata  = '0;

    // Reset: requests and beats present but nothing may be granted or routed.
    #22;
    check("rst_outputs", {fdma_raddr, fdma_rsize, fdma_rareq}, '0);
    check("rst_busy", busy_vec, 4'b0);
    check("rst_rvalid", rvalid_vec, 4'b0);
    req_v       = 4'b0;
    fdma_rvalid = 1'b0;
    ui_rstn     = 1'b1;
    tick();

    // T2: single burst on ch2
    req_v[1] = 1'b1;
    run_burst(3, 64, 4'b0010, 1'b1, "t2", w);

    // T5: stray beats while idle with no requests
    stray = 0;
    fdma_rvalid = 1'b1;
    repeat (5) begin
      tick();
      if (rvalid_vec !== 4'b0 || fdma_rareq !== 1'b0) stray++;
    end
    fdma_rvalid = 1'b0;
    check("t5_idle_stray", stray, 0);

    // T1: reset in the middle of a ch3 burst
    req_v[2] = 1'b1;
    wait_rareq(w);
    check("t1_grant", busy_vec, 4'b0100);
    req_v[2]   = 1'b0;
    fdma_rbusy = 1'b1;
    tick();
    fdma_rvalid = 1'b1;
    tick();
    tick();
    check("t1_mid_busy", rv3, 1'b1);
    ui_rstn = 1'b0;
    #1;
    check("t1_rst_outputs", {fdma_raddr, fdma_rsize, fdma_rareq}, '0);
    check("t1_rst_busy", busy_vec, 4'b0);
    check("t1_rst_rvalid", rvalid_vec, 4'b0);
    fdma_rbusy  = 1'b0;
    fdma_rvalid = 1'b0;
    tick();
    ui_rstn = 1'b1;

    // T3: all four requesting; first grant after reset is ch1, then rotate
    req_v = 4'b1111;
    for (int unsigned i = 0; i < 8; i++) begin
      run_burst(1, 2, 4'b0001 << (i % 4), 1'b0, "t3", w);
      check("t3_gap", w, 1);
    end

    // T4: finish ch3, then ch1+ch2 requesting -> ch1 wins via wrap
    req_v = 4'b0100;
    run_burst(0, 3, 4'b0100, 1'b1, "t4a", w);
    req_v = 4'b0011;
    run_burst(0, 0, 4'b0001, 1'b1, "t4b", w);
    run_burst(0, 4, 4'b0010, 1'b1, "t4c", w);

`ifdef FDMA_RD_ARB_TIMEOUT_EN
    // T6: ch4 never served; watchdog releases after 16 REQ cycles
    begin
      int unsigned hi;
      int unsigned early;
      req_v = 4'b1000;
      wait_rareq(w);
      check("t6_grant", busy_vec, 4'b1000);
      hi    = 0;
      early = 0;
      while (fdma_rareq && hi < 40) begin
        if (fdma_rd_timeout) early++;
        hi++;
        if (hi == 2) req_v[0] = 1'b1;
        tick();
      end
      check("t6_req_cycles", hi, 16);
      check("t6_early_pulse", early, 0);
      check("t6_pulse", fdma_rd_timeout, 1'b1);
      check("t6_done_busy", busy_vec, 4'b0);
      tick();
      check("t6_pulse_width", fdma_rd_timeout, 1'b0);
      req_v[3] = 1'b0;
      run_burst(0, 1, 4'b0001, 1'b1, "t6_next", w);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
